// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: operation encodings and default latencies.
// The decoder, hazard unit and mdu_unit all import this package.
package mdu_pkg;

  typedef enum logic [3:0] {
    MDU_NONE = 4'd0,
    MULT     = 4'd1,
    MULTU    = 4'd2,
    DIV      = 4'd3,
    DIVU     = 4'd4,
    MTHI     = 4'd5,
    MTLO     = 4'd6
  } md_op_e;

  localparam int MULT_CYCLES_DEFAULT = 5;
  localparam int DIV_CYCLES_DEFAULT  = 10;

endpackage

// File: rtl/mdu_unit.sv
// Execute-stage multiply/divide unit holding HI/LO. Operands are latched at
// start, results are computed combinationally and committed on the last busy cycle.
module mdu_unit
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEFAULT,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  logic [CNT_W-1:0] counter;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [3:0]       op_q;

  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] divisor;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic        res_write;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  assign busy     = (counter != '0);
  assign stall_md = busy | start;

  // Signed divide works on magnitudes so INT_MIN / -1 wraps to INT_MIN without
  // relying on simulator overflow behaviour; a zero divisor is masked to avoid X.
  always_comb begin
    prod_s    = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
    prod_u    = {32'b0, a_q} * {32'b0, b_q};
    divisor   = (b_q == 32'b0) ? 32'd1 : b_q;
    abs_a     = a_q[31] ? (32'b0 - a_q) : a_q;
    abs_b     = b_q[31] ? (32'b0 - b_q) : divisor;
    q_mag     = abs_a / abs_b;
    r_mag     = abs_a % abs_b;
    res_write = 1'b0;
    res_hi    = hi;
    res_lo    = lo;
    case (op_q)
      MULT: begin
        res_write = 1'b1;
        {res_hi, res_lo} = prod_s;
      end
      MULTU: begin
        res_write = 1'b1;
        {res_hi, res_lo} = prod_u;
      end
      DIV: begin
        res_write = (b_q != 32'b0);
        res_lo    = (a_q[31] ^ b_q[31]) ? (32'b0 - q_mag) : q_mag;
        res_hi    = a_q[31] ? (32'b0 - r_mag) : r_mag;
      end
      DIVU: begin
        res_write = (b_q != 32'b0);
        res_lo    = a_q / divisor;
        res_hi    = a_q % divisor;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      counter <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi      <= '0;
      lo      <= '0;
    end else if (busy) begin
      counter <= counter - CNT_W'(1);
      if (counter == CNT_W'(1) && res_write) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end else if (start) begin
      case (md_op)
        MULT, MULTU: begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= md_op;
          counter <= CNT_W'(MULT_CYCLES);
        end
        DIV, DIVU: begin
          a_q     <= a;
          b_q     <= b;
          op_q    <= md_op;
          counter <= CNT_W'(DIV_CYCLES);
        end
        MTHI:    hi <= a;
        MTLO:    lo <= a;
        default: ;
      endcase
    end
  end

endmodule
